// File: rtl/count_pkg.sv
// count_pkg: shared definitions for consumers of the free-running up counter.
// Holds the PWM controller state encoding and the default counter geometry.
package count_pkg;

    localparam int                     COUNT_WIDTH = 16;
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX   = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/count_wrap_detect.sv
// count_wrap_detect: samples an upstream up counter each clock and flags a
// wrap whenever the new value is below the previous sample. This catches both
// the natural rollover to zero and an upstream counter reset mid-period. A
// counter parked at zero never wraps. The first cycle after reset cannot wrap
// because no previous sample exists yet.
module count_wrap_detect
    import count_pkg::*;
#(
    parameter int WIDTH = COUNT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_count,
    output logic             o_wrap
);

    logic [WIDTH-1:0] r_count_q;
    logic             r_seen_q;

    // Remember the previous sample and whether that sample is meaningful.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count_q <= '0;
            r_seen_q  <= 1'b0;
        end else begin
            r_count_q <= i_count;
            r_seen_q  <= 1'b1;
        end
    end

    assign o_wrap = r_seen_q & (i_count < r_count_q);

endmodule

// File: rtl/count_pwm_16_bit.sv
// count_pwm_16_bit: registered PWM generator driven by an external up counter.
// Duty updates arrive over cfg_valid/cfg_ready into a shadow register and are
// only committed at a counter wrap, so a period is never cut short or stretched.
//
// Optional build macro COUNT_PWM_WRAP_PULSE_EN adds wrap_o and commit_o,
// registered one-cycle pulses following each wrap and each duty commit.
//
// state  | meaning
// S_IDLE | nothing programmed since reset, output held low
// S_PEND | shadow holds an accepted duty waiting for the next wrap
// S_RUN  | generating PWM from the active duty, ready for a new update
module count_pwm_16_bit
    import count_pkg::*;
#(
    parameter int WIDTH = COUNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count_i,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_duty,
    output logic             pwm_o,
    output logic             busy_o
`ifdef COUNT_PWM_WRAP_PULSE_EN
    ,
    output logic             wrap_o,
    output logic             commit_o
`endif
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_duty_active;
    logic [WIDTH-1:0] r_duty_shadow;
    logic [WIDTH-1:0] w_duty_cmp;
    logic             r_run;
    logic             r_pwm;
    logic             w_wrap;
    logic             w_accept;
    logic             w_commit;
    logic             w_pwm_en;

    count_wrap_detect #(
        .WIDTH (WIDTH)
    ) u_wrap_detect (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_count (count_i),
        .o_wrap  (w_wrap)
    );

    // Ready depends on state only so the upstream can hold valid without a loop.
    assign cfg_ready = (r_state != S_PEND);
    assign busy_o    = (r_state == S_PEND);
    assign w_accept  = cfg_valid & cfg_ready;

    // Next-state decode; a wrap in S_RUN together with an accept does not
    // commit, the new value waits for the following wrap.
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_PEND;
                end
            end
            S_PEND: begin
                if (w_wrap) begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_accept) begin
                    w_state_nxt = S_PEND;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Compare source: in the commit cycle the new duty is already in force,
    // so the period starting at this wrap uses it from its first count.
    always_comb begin
        w_duty_cmp = w_commit ? r_duty_shadow : r_duty_active;
        w_pwm_en   = (r_state == S_RUN) |
                     ((r_state == S_PEND) & (r_run | w_commit));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shadow capture on every accepted handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty_shadow <= '0;
        end else if (w_accept) begin
            r_duty_shadow <= cfg_duty;
        end
    end

    // Active duty and its valid flag change only at a commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty_active <= '0;
            r_run         <= 1'b0;
        end else if (w_commit) begin
            r_duty_active <= r_duty_shadow;
            r_run         <= 1'b1;
        end
    end

    // Registered PWM output, one cycle behind count_i.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= w_pwm_en & (count_i < w_duty_cmp);
        end
    end

    assign pwm_o = r_pwm;

`ifdef COUNT_PWM_WRAP_PULSE_EN
    logic r_wrap_pulse;
    logic r_commit_pulse;

    // Registered event pulses for observers that track period boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrap_pulse   <= 1'b0;
            r_commit_pulse <= 1'b0;
        end else begin
            r_wrap_pulse   <= w_wrap;
            r_commit_pulse <= w_commit;
        end
    end

    assign wrap_o   = r_wrap_pulse;
    assign commit_o = r_commit_pulse;
`endif

endmodule

// File: doc/count_pwm_16_bit.md
Name: count_pwm_16_bit

Overview:
Downstream consumer of the free-running 16-bit up counter. It samples the counter value each clock and produces a registered PWM output, `pwm_o`, by comparing the count against an active duty value. New duty values arrive over a valid/ready handshake and are held in a shadow register. The shadow value is committed only at counter wrap, so the output is glitch-free.

Parameters:
- WIDTH, 16: width of the count input and the duty values. The counter wraps at 2^WIDTH.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- count_i  input  WIDTH  current value of the upstream up counter.
- cfg_valid  input  1  a duty update is offered on cfg_duty.
- cfg_ready  output  1  the block can accept a duty update.
- cfg_duty  input  WIDTH  requested duty in counts (number of high counts per period).
- pwm_o  output  1  registered PWM output.
- busy_o  output  1  high while an accepted update is waiting for a wrap.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=S_IDLE; duty_active=0; duty_shadow=0; count_q=0; seen_q=0.
  - Outputs: pwm_o=0, busy_o=0, cfg_ready=1.
- Sampling: every non-reset cycle, count_q<=count_i and seen_q<=1.
- Wrap detection: wrap = seen_q & (count_i < count_q).
  - Covers the normal 0xFFFF->0x0000 rollover.
  - Also covers the upstream counter being reset mid-period, since its count drops.
  - A counter held at 0 gives no wrap.
- Handshake: accept = cfg_valid & cfg_ready. On accept, duty_shadow<=cfg_duty.
  - cfg_valid may stay high across cycles.
  - cfg_duty must stay stable while cfg_valid=1 and cfg_ready=0.
- cfg_ready = (state != S_PEND). This is combinational from state only and does not depend on cfg_valid.
- States:
  - S_IDLE: no duty programmed; pwm_o is forced to 0. On accept -> S_PEND.
  - S_PEND: update waiting, busy_o=1. On wrap: duty_active<=duty_shadow -> S_RUN.
  - S_RUN: generating PWM. On accept -> S_PEND; pwm_o keeps using the old duty_active until the wrap.
- Simultaneous events:
  - accept and wrap in the same cycle in S_RUN: go to S_PEND. The new value is committed at the next wrap, not this one.
  - In S_PEND, accept cannot happen because cfg_ready=0.
- PWM compare: pwm_o <= (state==S_RUN or state==S_PEND-with-duty_active-valid) & (count_i < duty_active).
  - Compare is unsigned, WIDTH bits; one-cycle latency from count_i to pwm_o.
  - duty_active is valid once the block has been in S_RUN at least once (track with a flag, run_q).
  - duty=0: pwm_o is always 0.
  - duty=0xFFFF: high for 65535 of 65536 counts.
  - 100% duty is not representable; this is intentional.
- Commit timing: the commit happens in the wrap cycle, so the compare in that same cycle (count_i=0) already uses the new duty.
- Reset mid-operation: all state is discarded, including any pending update. The PWM restarts only after a fresh accept followed by a wrap.

Optional Feature:
- Macro: COUNT_PWM_WRAP_PULSE_EN.
- Defined:
  - Adds output port `wrap_o` (1 bit): a registered one-cycle pulse one clk after each detected wrap. Reset value 0.
  - Adds output port `commit_o` (1 bit): a one-cycle pulse, registered, when duty_shadow is committed.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Shared package `count_pkg` holds:
  - the state encoding S_IDLE=2'd0, S_PEND=2'd1, S_RUN=2'd2;
  - COUNT_WIDTH=16;
  - COUNT_MAX=16'hFFFF.
- One natural sub-module, `count_wrap_detect`: holds count_q and seen_q and outputs wrap. It is reusable by other counter consumers.
- The handshake, FSM and compare stay in the top module.

Test Plan:
- Reset: rst=1 for 3 clk, count_i sweeping -> pwm_o=0, busy_o=0, cfg_ready=1 throughout; after release with no cfg, pwm_o stays 0 for a full 65536-count period.
- Basic duty: with the counter free-running from 0, offer cfg_duty=0x0100 once.
  - Required: busy_o=1 until wrap.
  - Then, for each following period, pwm_o=1 for exactly 256 consecutive clk, then 0 for 65280, lagging count_i by 1 clk.
- Glitch-free update: in S_RUN with duty=0x8000, offer 0x0010 at count=0x1234 -> old duty is kept to the end of the period; the new 16-count pulse starts at the next 0x0000.
- Boundaries:
  - duty=0x0000 -> pwm_o never high.
  - duty=0xFFFF -> pwm_o low only for the single count 0xFFFF (seen 1 clk later).
- Back-pressure: hold cfg_valid=1 with 0x0020 while S_PEND holds an earlier 0x0040 -> cfg_ready=0 until wrap; 0x0040 commits; 0x0020 is accepted the next cycle and commits one period later.
- Upstream reset: drop count_i from 0x3000 to 0 mid-period with an update pending -> treated as wrap and the update commits; then drive rst=1 mid-period -> pwm_o=0 and the pending update is lost.
